// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths and queue entry type for the fetch path
package fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;
  localparam int QDEPTH     = 2;

  // One returned instruction word together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/m_fetch_queue.sv
// rtl/m_fetch_queue.sv - 2-entry shift FIFO holding returned fetch words
//
// Ports:
//   w_clk, w_rst   clock, asynchronous active-high reset
//   i_push         write i_push_data this cycle
//   i_push_data    entry to write
//   i_pop          consume the head this cycle
//   i_flush        drop every entry (wins over push/pop)
//   o_count        number of valid entries (0..2)
//   o_head_valid   head entry is valid
//   o_head         head entry (register, stable until popped)
module m_fetch_queue
  import fetch_pkg::*;
(
  input  logic         w_clk,
  input  logic         w_rst,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_count,
  output logic         o_head_valid,
  output fetch_entry_t o_head
);

  fetch_entry_t r_q0;
  fetch_entry_t r_q1;
  logic [1:0]   r_count;

  logic w_pop_ok;
  logic w_push_ok;

  // Entry 0 is always the head, so the output needs no read mux.
  assign w_pop_ok  = i_pop & (r_count != 2'd0);
  assign w_push_ok = i_push & ((r_count != 2'(QDEPTH)) | w_pop_ok);

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_q0    <= '0;
      r_q1    <= '0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10: begin
          if (r_count == 2'd0) r_q0 <= i_push_data;
          else                 r_q1 <= i_push_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_q0    <= r_q1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: occupancy unchanged, shift then append.
          if (r_count == 2'd1) begin
            r_q0 <= i_push_data;
          end else begin
            r_q0 <= r_q1;
            r_q1 <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count      = r_count;
  assign o_head_valid = (r_count != 2'd0);
  assign o_head       = r_q0;

endmodule

// File: rtl/m_fetch_ctrl.sv
// rtl/m_fetch_ctrl.sv - instruction fetch sequencer for a one-cycle sync memory
//
// Ports:
//   w_clk, w_rst    clock, asynchronous active-high reset
//   w_mem_addr      memory address, always the current PC register
//   w_mem_data      read data for the address presented last cycle
//   w_redirect      one-cycle branch/jump request
//   w_redirect_pc   redirect target (word aligned)
//   r_inst_valid    queue head valid toward decode
//   r_inst          instruction at queue head
//   r_inst_pc       PC of r_inst
//   w_inst_ready    decode accepts the head this cycle
//   r_halted        sequential fetch passed LAST_PC and everything drained
module m_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] LAST_PC  = 32'd12,
  parameter int          QDEPTH   = 2
) (
  input  logic        w_clk,
  input  logic        w_rst,
  output logic [31:0] w_mem_addr,
  input  logic [31:0] w_mem_data,
  input  logic        w_redirect,
  input  logic [31:0] w_redirect_pc,
  output logic        r_inst_valid,
  output logic [31:0] r_inst,
  output logic [31:0] r_inst_pc,
  input  logic        w_inst_ready,
  output logic        r_halted
);

  import fetch_pkg::*;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_if_pc;
  logic            r_inflight;
  logic            r_halt_q;

  logic            w_pop;
  logic [2:0]      w_occ;
  logic            w_issue;
  logic            w_push;
  logic [1:0]      w_count;
  logic            w_head_valid;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;

  assign w_pop = w_head_valid & w_inst_ready;

  // Occupancy the queue will have once the in-flight word lands; issuing only
  // while this is below the depth means a returning word always has a slot.
  assign w_occ = {1'b0, w_count} - {2'b00, w_pop} + {2'b00, r_inflight};

  assign w_issue = ~w_redirect & (r_pc <= LAST_PC) & (w_occ < 3'(QDEPTH));

  // Data arriving in a redirect cycle belongs to the abandoned path.
  assign w_push           = r_inflight & ~w_redirect;
  assign w_push_data.inst = w_mem_data;
  assign w_push_data.pc   = r_if_pc;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_pc       <= RESET_PC;
      r_if_pc    <= '0;
      r_inflight <= 1'b0;
      r_halt_q   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_redirect) begin
        r_pc <= w_redirect_pc;
      end else if (w_issue) begin
        r_pc    <= r_pc + 32'(INST_BYTES);
        r_if_pc <= r_pc;
      end
      if (w_redirect) begin
        r_halt_q <= 1'b0;
      end else if ((r_pc > LAST_PC) && !r_inflight && (w_count == 2'd0)) begin
        r_halt_q <= 1'b1;
      end
    end
  end

  m_fetch_queue u_queue (
    .w_clk        (w_clk),
    .w_rst        (w_rst),
    .i_push       (w_push),
    .i_push_data  (w_push_data),
    .i_pop        (w_pop),
    .i_flush      (w_redirect),
    .o_count      (w_count),
    .o_head_valid (w_head_valid),
    .o_head       (w_head)
  );

  assign w_mem_addr   = r_pc;
  assign r_inst_valid = w_head_valid;
  assign r_inst       = w_head.inst;
  assign r_inst_pc    = w_head.pc;
  assign r_halted     = r_halt_q;

endmodule
